// File: rtl/spi_rx.sv
// spi_rx: peripheral-side SPI deserializer (mode 0, MSB first, active-low select).
//
// Synchronizes the asynchronous select, serial clock and serial data pins into the
// clk_in domain, shifts one bit per rising serial-clock edge and reports each
// completed word with a one-cycle valid pulse. Frames that end early are reported
// with a one-cycle error pulse instead of being delivered.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_in          asynchronous active-low reset
//   data_in         serial data pin (MOSI), asynchronous
//   data_clk_in     serial clock pin, idles low, asynchronous
//   sel_in          frame select pin, active-low, asynchronous
//   data_out        last complete word, held until the next word completes
//   data_valid_out  one-cycle pulse when data_out updates
//   frame_error_out one-cycle pulse when a frame ends with 1..DATA_WIDTH-1 bits
//   busy_out        high while a frame is being received
module spi_rx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  frame_error_out,
    output logic                  busy_out
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StRecv,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0]  fill_q, fill_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic [DATA_WIDTH-2:0]   shift_q, shift_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic sel_s, sclk_s, data_s, sclk_rise, last_bit;

    assign sel_s     = sel_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign last_bit  = sclk_rise && (cnt_q == LastCnt);

    // Synchronizers. fill_q marks when the sel chain holds only post-reset pin
    // samples; until then its reset value of 1 must not let ARM leave for IDLE,
    // otherwise a frame already in progress at reset release would be joined.
    always_comb begin
        sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], sel_in};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], data_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
    end

    // State register and datapath registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StArm;
            sel_sync_q  <= '1;
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_sync_q  <= sel_sync_d;
            sclk_sync_q <= sclk_sync_d;
            data_sync_q <= data_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArm:  if (fill_q[SYNC_STAGES-1] && sel_s) state_d = StIdle;
            StIdle: if (!sel_s) state_d = StRecv;
            StRecv: begin
                // The final bit wins over a coincident select release.
                if (last_bit) state_d = StHold;
                else if (sel_s) state_d = StIdle;
            end
            StHold: if (sel_s) state_d = StIdle;
            default: state_d = StArm;
        endcase
    end

    // Datapath and outputs.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: if (!sel_s) cnt_d = '0;
            StRecv: begin
                if (last_bit) begin
                    data_d  = {shift_q, data_s};
                    valid_d = 1'b1;
                end else if (sel_s) begin
                    // A bit arriving together with the release is discarded but
                    // still makes the frame a truncated one.
                    err_d = (cnt_q != '0) || sclk_rise;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-3:0], data_s};
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    assign busy_out        = (state_q == StRecv);
    assign data_out        = data_q;
    assign data_valid_out  = valid_q;
    assign frame_error_out = err_q;

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: the driver pushes the expected outcome of each
// frame, a monitor pops and compares whenever the receiver pulses an output.
module tb_spi_rx;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         data_in;
    logic         data_clk_in;
    logic         sel_in;
    logic [W-1:0] data_out;
    logic         data_valid_out;
    logic         frame_error_out;
    logic         busy_out;

    spi_rx #(
        .DATA_WIDTH (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_clk_in    (data_clk_in),
        .sel_in         (sel_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .frame_error_out(frame_error_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Reference model: a frame delivers its first W bits if it has at least W
    // rises while selected; otherwise any bit at all makes it an error.
    task automatic expect_frame(input logic [15:0] bits, input int n);
        exp_t e;
        if (n >= W) begin
            e.is_err = 1'b0;
            e.val    = W'(bits >> (n - W));
            exp_q.push_back(e);
        end else if (n > 0) begin
            e.is_err = 1'b1;
            e.val    = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bit(input logic b, input int half);
        data_in = b;
        wait_clk(half);
        data_clk_in = 1'b1;
        wait_clk(half);
        data_clk_in = 1'b0;
    endtask

    // Sends n bits, first bit at bits[n-1]. With coincide set, select is released
    // at the same instant as the last serial clock rise.
    task automatic frame(input logic [15:0] bits, input int n, input int half,
                         input bit coincide);
        expect_frame(bits, n);
        sel_in = 1'b0;
        wait_clk(half);
        for (int i = 0; i < n; i++) begin
            data_in = bits[n-1-i];
            wait_clk(half);
            if (coincide && i == n - 1) sel_in = 1'b1;
            data_clk_in = 1'b1;
            wait_clk(half);
            if (i == 0 && !(coincide && n == 1)) check("busy_in_frame", busy_out, 1);
            data_clk_in = 1'b0;
        end
        wait_clk(half);
        sel_in = 1'b1;
        wait_clk(half);
    endtask

    task automatic pulse_reset_start();
        @(negedge clk_in);
        #2 rst_in = 1'b0;
    endtask

    task automatic pulse_reset_end();
        @(negedge clk_in);
        #2 rst_in = 1'b1;
    endtask

    // Monitor
    logic [W-1:0] hold_val = '0;
    logic         prev_pulse = 1'b0;

    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            check("reset_data", data_out, 0);
            check("reset_valid", data_valid_out, 0);
            check("reset_error", frame_error_out, 0);
            check("reset_busy", busy_out, 0);
            hold_val   = '0;
            prev_pulse = 1'b0;
        end else begin
            if (data_valid_out || frame_error_out) begin
                check("no_overlap", {data_valid_out, frame_error_out} == 2'b11, 0);
                check("no_back_to_back", prev_pulse, 0);
                check("busy_after_pulse", busy_out, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {data_valid_out, frame_error_out}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", frame_error_out, e.is_err);
                    if (!e.is_err) begin
                        check("word", data_out, e.val);
                        hold_val = e.val;
                    end
                end
            end
            check("data_hold", data_out, hold_val);
            prev_pulse = data_valid_out || frame_error_out;
        end
    end

    initial begin
        logic [15:0] bits;
        int          n;
        int          half;
        bit          co;
        int          guard;

        rst_in      = 1'b0;
        sel_in      = 1'b1;
        data_clk_in = 1'b0;
        data_in     = 1'b0;
        wait_clk(5);
        pulse_reset_end();
        wait_clk(10);

        frame(16'h00A5, 8, 50, 0);
        frame(16'h003C, 8, 50, 0);
        frame(16'h00FF, 8, 50, 0);
        frame(16'h0000, 8, 50, 0);
        frame(16'h0005, 3, 50, 0);               // aborted after 3 rises
        frame(16'h0081, 8, 50, 0);
        frame(16'h0187, 9, 50, 0);               // 0xC3 then an extra 1
        frame(16'h00A7, 8, 20, 1);               // final rise coincides with release
        frame(16'h0015, 5, 20, 1);               // non-final rise coincides

        // Reset in the middle of 0x5A, released while still selected.
        sel_in = 1'b0;
        wait_clk(50);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> (7 - i)), 50);
        pulse_reset_start();
        wait_clk(3);
        pulse_reset_end();
        for (int i = 4; i < 8; i++) send_bit(1'(8'h5A >> (7 - i)), 50);
        wait_clk(50);
        sel_in = 1'b1;
        wait_clk(50);
        frame(16'h0012, 8, 50, 0);

        // Select low and serial clock toggling across reset release.
        pulse_reset_start();
        sel_in = 1'b0;
        send_bit(1'b1, 5);
        send_bit(1'b0, 5);
        pulse_reset_end();
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 5);
        wait_clk(5);
        sel_in = 1'b1;
        wait_clk(10);
        frame(16'h006E, 8, 30, 0);

        for (int k = 0; k < 40; k++) begin
            n    = $urandom_range(0, 10);
            bits = 16'($urandom);
            half = $urandom_range(4, 20);
            co   = (n > 0) && ($urandom_range(0, 3) == 0);
            frame(bits, n, half, co);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            wait_clk(1);
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        wait_clk(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_rx.md
# spi_rx

SPI receiver: peripheral-side deserializer for frames produced by our SPI transmitter (mode 0, MSB first, active-low select). It synchronizes the external `sel_in`, `data_clk_in` and `data_in` lines into the `clk_in` domain, shifts in one bit per rising serial-clock edge, and presents each completed word with a one-cycle valid pulse. Truncated frames are reported, not delivered. It sits at the FPGA pin boundary, ahead of any consumer of inbound SPI words.

## Interface
- `DATA_WIDTH`, 8: bits per word; must match the transmitter.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on each input line; must be ≥2.
- `clk_in`  input  1: system clock; all logic on the rising edge.
- `rst_in`  input  1: reset, asynchronous, active-low.
- `data_in`  input  1: serial data (MOSI); asynchronous to `clk_in`.
- `data_clk_in`  input  1: serial clock; idles low; asynchronous.
- `sel_in`  input  1: frame select, active-low; asynchronous.
- `data_out`  output  DATA_WIDTH: last complete word; holds until the next word completes.
- `data_valid_out`  output  1: one-cycle pulse when `data_out` updates.
- `frame_error_out`  output  1: one-cycle pulse when a frame ends with 1..DATA_WIDTH-1 bits.
- `busy_out`  output  1: high while in RECV.

## Operation
- All three inputs pass through `SYNC_STAGES` flops. Reset values: sel chain 1, clk and data chains 0. Synchronized sclk is also registered once for edge detection, giving `sclk_rise = sclk_s & ~sclk_prev`.
- Data line has the same synchronizer depth as sclk, so the data sample taken on `sclk_rise` is the value present at the pin edge.
- FSM states:
  - ARM: entered on reset. Goes to IDLE once synchronized sel = 1. This prevents joining a frame in progress.
  - IDLE: on synchronized sel = 0, clear the bit counter and go to RECV.
  - RECV: on each `sclk_rise`, shift left and insert the data sample at the LSB; counter += 1.
    - When the DATA_WIDTH-th bit is shifted, go to HOLD.
    - If sel returns to 1 with counter 1..DATA_WIDTH-1, pulse `frame_error_out` and go to IDLE.
    - If sel returns to 1 with counter 0, go to IDLE silently (empty frame).
  - HOLD: all further sclk edges are ignored. On sel = 1, go to IDLE.
- Output update: in the cycle the last bit is shifted, `data_out` <= {shift[DATA_WIDTH-2:0], sample} and `data_valid_out` <= 1.
- Simultaneous events:
  - If the final `sclk_rise` and a sel deassertion are seen in the same cycle, the word is accepted: valid pulse, no error.
  - If a non-final `sclk_rise` and a sel deassertion coincide, the bit is discarded and an error is reported.
- Counter width is $clog2(DATA_WIDTH+1). It never wraps, because HOLD blocks further counting.
- Reset mid-frame: every register is cleared asynchronously and the FSM returns to ARM. The partial word is lost and no error pulse is generated.

## Timing
- Reset values: `data_out` = 0, `data_valid_out` = 0, `frame_error_out` = 0, `busy_out` = 0, FSM = ARM.
- Latency: a pin edge on `data_clk_in` is registered into the shift register on the (SYNC_STAGES+1)-th `clk_in` rising edge after the pin edge. For the last bit, `data_valid_out` is high in the following cycle.
- A sel deassertion produces `frame_error_out` SYNC_STAGES+1 edges after the pin edge.
- Input constraint: sclk high and low phases must each last ≥ SYNC_STAGES+1 `clk_in` cycles. Data must be stable over the same window around each sclk rise. The transmitter at DATA_PERIOD = 100 gives 50-cycle phases.
- Back-to-back frames: sel high for ≥ SYNC_STAGES+1 cycles between frames is required to re-enter IDLE.
- `data_valid_out` and `frame_error_out` are never high in the same cycle, and never high for two consecutive cycles.

## Test plan
- Transmitter (DATA_PERIOD = 100) sends 0xA5 -> exactly one `data_valid_out` pulse, `data_out` = 0xA5, `frame_error_out` stays 0, `busy_out` falls after the pulse.
- Back-to-back frames 0x3C, 0xFF, 0x00 -> three valid pulses, values in order. `data_out` holds 0x3C until the 0xFF pulse.
- Frame aborted by sel rising after 3 sclk rises -> one `frame_error_out` pulse, no valid pulse, `data_out` keeps its previous value. A following frame 0x81 is received correctly.
- Nine sclk rises inside one select window carrying 0xC3 then a 1 -> valid with `data_out` = 0xC3; the ninth edge is ignored; no error.
- `rst_in` driven low after 4 bits of 0x5A, released while sel is still low, remaining edges continue -> no valid and no error until sel goes high. The next full frame 0x12 is received.
- Sel low and sclk toggling at reset release -> FSM stays in ARM; nothing is reported until a complete new frame arrives.
